// File: rtl/trafik_monitor.sv
// Traffic-light lamp monitor: checks the lamp pattern, phase order and phase dwell times, and counts full cycles.
// Optional dwell-time checking (codes 3/4) is built only when TRAFIK_MON_DWELL_CHECK_EN is defined.
module trafik_monitor #(
   parameter int RED_MIN = 239_000_000,
   parameter int RED_MAX = 241_000_000,
   parameter int AMB_MIN = 49_000_000,
   parameter int AMB_MAX = 51_000_000,
   parameter int GRN_MIN = 119_000_000,
   parameter int GRN_MAX = 121_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  led,
   input  logic        clr_fault,
   output logic [1:0]  phase,
   output logic        phase_valid,
   output logic        fault,
   output logic [2:0]  fault_code,
   output logic [15:0] cycle_cnt
);

   typedef enum logic [2:0] {INIT, RED, AMBER, GREEN, FAULT} state_t;

   state_t      state, stateNext;
   logic [2:0]  ledReg;
   logic        sampled;
   logic [1:0]  phaseReg, phaseNext;
   logic [2:0]  codeReg, codeNext;
   logic [15:0] cycleNext;
   logic [1:0]  ledPhase, succPhase;
   logic        ledLegal;

`ifdef TRAFIK_MON_DWELL_CHECK_EN
   logic [27:0] dwell, dwellNext, dwellInc, curMin, curLim;
   logic        firstPhase, firstNext;
`endif

   function automatic state_t toState(input logic [1:0] p);
      case (p)
         2'd0:    return RED;
         2'd1:    return AMBER;
         default: return GREEN;
      endcase
   endfunction

   always_comb begin
      ledLegal = 1'b1;
      ledPhase = 2'd3;
      case (ledReg)
         3'b110:  ledPhase = 2'd0;
         3'b101:  ledPhase = 2'd1;
         3'b011:  ledPhase = 2'd2;
         default: ledLegal = 1'b0;
      endcase
      succPhase = (phaseReg == 2'd2) ? 2'd0 : phaseReg + 2'd1;
   end

`ifdef TRAFIK_MON_DWELL_CHECK_EN
   // Limits of the phase currently being tracked; the long check fires as the count reaches MAX+1.
   always_comb begin
      dwellInc = (dwell == 28'hFFF_FFFF) ? dwell : dwell + 28'd1;
      case (phaseReg)
         2'd0: begin curMin = 28'(RED_MIN); curLim = 28'(RED_MAX + 1); end
         2'd1: begin curMin = 28'(AMB_MIN); curLim = 28'(AMB_MAX + 1); end
         default: begin curMin = 28'(GRN_MIN); curLim = 28'(GRN_MAX + 1); end
      endcase
   end
`endif

   always_comb begin
      stateNext = state;
      phaseNext = phaseReg;
      codeNext  = codeReg;
      cycleNext = cycle_cnt;
`ifdef TRAFIK_MON_DWELL_CHECK_EN
      dwellNext = dwell;
      firstNext = firstPhase;
`endif
      if (clr_fault) begin
         stateNext = INIT;
         phaseNext = 2'd3;
         codeNext  = 3'd0;
`ifdef TRAFIK_MON_DWELL_CHECK_EN
         dwellNext = 28'd0;
`endif
      end else begin
         case (state)
            // The register holds all-ones until the first real sample arrives, so wait for it.
            INIT: if (sampled) begin
               if (!ledLegal) begin
                  stateNext = FAULT;
                  codeNext  = 3'd1;
               end else begin
                  stateNext = toState(ledPhase);
                  phaseNext = ledPhase;
`ifdef TRAFIK_MON_DWELL_CHECK_EN
                  dwellNext = 28'd1;
                  firstNext = 1'b1;
`endif
               end
            end
            RED, AMBER, GREEN: begin
               if (!ledLegal) begin
                  stateNext = FAULT;
                  codeNext  = 3'd1;
               end else if (ledPhase != phaseReg) begin
                  if (ledPhase != succPhase) begin
                     stateNext = FAULT;
                     codeNext  = 3'd2;
`ifdef TRAFIK_MON_DWELL_CHECK_EN
                  end else if (!firstPhase && dwell < curMin) begin
                     stateNext = FAULT;
                     codeNext  = 3'd3;
`endif
                  end else begin
                     stateNext = toState(ledPhase);
                     phaseNext = ledPhase;
                     if (phaseReg == 2'd2 && cycle_cnt != 16'hFFFF)
                        cycleNext = cycle_cnt + 16'd1;
`ifdef TRAFIK_MON_DWELL_CHECK_EN
                     dwellNext = 28'd1;
                     firstNext = 1'b0;
`endif
                  end
               end else begin
`ifdef TRAFIK_MON_DWELL_CHECK_EN
                  dwellNext = dwellInc;
                  if (dwellInc == curLim) begin
                     stateNext = FAULT;
                     codeNext  = 3'd4;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         ledReg    <= 3'b111;
         sampled   <= 1'b0;
         phaseReg  <= 2'd3;
         codeReg   <= 3'd0;
         cycle_cnt <= 16'd0;
      end else begin
         state     <= stateNext;
         ledReg    <= led;
         sampled   <= 1'b1;
         phaseReg  <= phaseNext;
         codeReg   <= codeNext;
         cycle_cnt <= cycleNext;
      end
   end

`ifdef TRAFIK_MON_DWELL_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell      <= 28'd0;
         firstPhase <= 1'b0;
      end else begin
         dwell      <= dwellNext;
         firstPhase <= firstNext;
      end
   end
`endif

   assign phase       = phaseReg;
   assign phase_valid = (state == RED) || (state == AMBER) || (state == GREEN);
   assign fault       = (state == FAULT);
   assign fault_code  = codeReg;

endmodule

// File: tb/tb_trafik_monitor.sv
// Bench for trafik_monitor: directed scenarios plus random phase sequences, checked each cycle against a
// cycle-level model of the lamp rules (dwell expectations follow TRAFIK_MON_DWELL_CHECK_EN).
module tb_trafik_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  led;
   logic        clr_fault;
   logic [1:0]  phase;
   logic        phase_valid;
   logic        fault;
   logic [2:0]  fault_code;
   logic [15:0] cycle_cnt;

   int checks = 0;
   int failures = 0;

`ifdef TRAFIK_MON_DWELL_CHECK_EN
   localparam bit DWELL = 1'b1;
`else
   localparam bit DWELL = 1'b0;
`endif

   int minOf [3] = '{8, 3, 6};
   int maxOf [3] = '{12, 5, 8};

   // Model: mMode -1 waiting, 0..2 tracking that phase, 3 faulted.
   int         mMode, mPhase, mCode, mCnt, mRun;
   bit         mFirst, mSampled;
   logic [2:0] mLed;

   trafik_monitor #(
      .RED_MIN(8), .RED_MAX(12), .AMB_MIN(3), .AMB_MAX(5), .GRN_MIN(6), .GRN_MAX(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .led(led), .clr_fault(clr_fault),
      .phase(phase), .phase_valid(phase_valid), .fault(fault),
      .fault_code(fault_code), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] patOf(input int p);
      case (p)
         0:       return 3'b110;
         1:       return 3'b101;
         default: return 3'b011;
      endcase
   endfunction

   function automatic int patPhase(input logic [2:0] v);
      if (v == 3'b110) return 0;
      if (v == 3'b101) return 1;
      if (v == 3'b011) return 2;
      return -1;
   endfunction

   task automatic modelReset();
      mMode = -1; mPhase = 3; mCode = 0; mCnt = 0; mRun = 0;
      mFirst = 1'b0; mSampled = 1'b0; mLed = 3'b111;
   endtask

   task automatic modelFault(input int c);
      mMode = 3;
      mCode = c;
   endtask

   // One clock edge of the rules: check the previously sampled pattern, then sample the new one.
   task automatic modelEdge(input bit clr);
      int p;
      p = patPhase(mLed);
      if (clr) begin
         mMode = -1; mPhase = 3; mCode = 0; mRun = 0; mFirst = 1'b1;
      end else if (mMode != 3 && mSampled) begin
         if (p < 0) modelFault(1);
         else if (mMode == -1) begin
            mMode = p; mPhase = p; mRun = 1; mFirst = 1'b1;
         end else if (p != mMode) begin
            if (p != (mMode + 1) % 3) modelFault(2);
            else if (DWELL && !mFirst && mRun < minOf[mMode]) modelFault(3);
            else begin
               if (mMode == 2 && mCnt < 65535) mCnt++;
               mMode = p; mPhase = p; mRun = 1; mFirst = 1'b0;
            end
         end else begin
            mRun++;
            if (DWELL && mRun == maxOf[mMode] + 1) modelFault(4);
         end
      end
      mLed = led;
      mSampled = 1'b1;
   endtask

   task automatic checkVal(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ".phase"}, int'(phase), mPhase);
      checkVal({tag, ".phase_valid"}, int'(phase_valid), (mMode >= 0 && mMode <= 2) ? 1 : 0);
      checkVal({tag, ".fault"}, int'(fault), (mMode == 3) ? 1 : 0);
      checkVal({tag, ".fault_code"}, int'(fault_code), mCode);
      checkVal({tag, ".cycle_cnt"}, int'(cycle_cnt), mCnt);
   endtask

   task automatic applyStimulus(input logic [2:0] ledv, input bit clrv);
      led = ledv;
      clr_fault = clrv;
      @(posedge clk);
      if (rst_n) modelEdge(clrv);
      #1;
      checkOutput("cyc");
   endtask

   task automatic hold(input int p, input int n);
      repeat (n) applyStimulus(patOf(p), 1'b0);
   endtask

   task automatic resetPulse();
      rst_n = 1'b0;
      modelReset();
      #1;
      checkVal("rst.phase", int'(phase), 3);
      checkVal("rst.phase_valid", int'(phase_valid), 0);
      checkVal("rst.fault", int'(fault), 0);
      checkVal("rst.fault_code", int'(fault_code), 0);
      checkVal("rst.cycle_cnt", int'(cycle_cnt), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int cntBefore, gp, len, r;
      rst_n = 1'b0;
      led = 3'b110;
      clr_fault = 1'b0;
      @(posedge clk);
      #1;
      resetPulse();

      // Legal loop three times, then RED to complete the third cycle.
      for (int i = 0; i < 3; i++) begin
         hold(0, 10); hold(1, 4); hold(2, 7);
      end
      hold(0, 2);
      checkVal("loop.cycle_cnt", int'(cycle_cnt), 3);
      checkVal("loop.fault", int'(fault), 0);

      // RED then straight to GREEN: illegal transition two edges later.
      resetPulse();
      hold(0, 10);
      hold(2, 2);
      checkVal("skip.code", int'(fault_code), 2);
      checkVal("skip.phase", int'(phase), 0);
      hold(1, 3);
      checkVal("skip.sticky", int'(fault_code), 2);

      // Clear while faulted, with GREEN on the lamps.
      cntBefore = mCnt;
      applyStimulus(patOf(2), 1'b1);
      checkVal("clr.phase_init", int'(phase), 3);
      checkVal("clr.fault", int'(fault), 0);
      applyStimulus(patOf(2), 1'b0);
      checkVal("clr.phase_green", int'(phase), 2);
      checkVal("clr.cycle_cnt", int'(cycle_cnt), cntBefore);
      hold(2, 3);

      // Illegal pattern mid-AMBER, then GREEN.
      hold(0, 10); hold(1, 2);
      applyStimulus(3'b100, 1'b0);
      hold(2, 3);
      checkVal("glitch.code", int'(fault_code), 1);

      // AMBER held too long, then too short.
      applyStimulus(patOf(0), 1'b1);
      hold(0, 9); hold(1, 6); hold(2, 2);
`ifdef TRAFIK_MON_DWELL_CHECK_EN
      checkVal("long.code", int'(fault_code), 4);
`endif
      applyStimulus(patOf(0), 1'b1);
      hold(0, 9); hold(1, 2); hold(2, 2);
`ifdef TRAFIK_MON_DWELL_CHECK_EN
      checkVal("short.code", int'(fault_code), 3);
`endif

      // Reset in the middle of a GREEN dwell, then a short first GREEN.
      applyStimulus(patOf(0), 1'b1);
      hold(0, 9); hold(1, 4); hold(2, 5);
      resetPulse();
      hold(2, 3); hold(0, 3);
      checkVal("rstmid.fault", int'(fault), 0);
      checkVal("rstmid.phase", int'(phase), 0);

      // Random phase lengths around the limits, with glitches, wrong jumps and clears.
      gp = 0;
      for (int seg = 0; seg < 80; seg++) begin
         r = $urandom_range(0, 19);
         if (mMode == 3 || r == 0) applyStimulus(patOf(gp), 1'b1);
         if (r == 1) applyStimulus(3'($urandom_range(0, 7)), 1'b0);
         else if (r == 2) gp = (gp + 2) % 3;
         len = $urandom_range(minOf[gp] - 2, maxOf[gp] + 2);
         hold(gp, len);
         gp = (gp + 1) % 3;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trafik_monitor.md
TRAFIK_MONITOR -- requirements
Module: trafik_monitor

Interface
REQ-001 Parameter RED_MIN, default 239_000_000, minimum legal RED dwell in clk cycles.
REQ-002 Parameter RED_MAX, default 241_000_000, maximum legal RED dwell.
REQ-003 Parameter AMB_MIN / AMB_MAX, defaults 49_000_000 / 51_000_000, AMBER dwell limits.
REQ-004 Parameter GRN_MIN / GRN_MAX, defaults 119_000_000 / 121_000_000, GREEN dwell limits.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 led  input  3  observed active-low lamp drive: 3'b110 RED, 3'b101 AMBER, 3'b011 GREEN, same clock domain.
REQ-008 clr_fault  input  1  single-cycle pulse; clears the fault and restarts monitoring.
REQ-009 phase  output  2  current phase: 0 RED, 1 AMBER, 2 GREEN, 3 none.
REQ-010 phase_valid  output  1  high while tracking a legal phase.
REQ-011 fault  output  1  sticky fault flag.
REQ-012 fault_code  output  3  0 none, 1 illegal pattern, 2 illegal transition, 3 dwell short, 4 dwell long.
REQ-013 cycle_cnt  output  16  number of completed GREEN->RED transitions.

Function
REQ-014 led SHALL be registered once; all checks SHALL use the registered value, so a stimulus at edge k SHALL be reflected on the outputs after edge k+2.
REQ-015 FSM states SHALL be INIT, RED, AMBER, GREEN, FAULT.
REQ-016 INIT: the first legal pattern SHALL enter the matching state, with the dwell counter set to 1 and no minimum check applied to this partial first phase.
REQ-017 Legal transitions SHALL be RED->AMBER, AMBER->GREEN and GREEN->RED only; any other change between legal patterns SHALL set code 2.
REQ-018 Any pattern that is not one of the three legal codes SHALL set code 1, in any state except FAULT.
REQ-019 Dwell counter: 28 bits, incremented each cycle the pattern is unchanged, saturating at all-ones, reloaded to 1 on each phase change.
REQ-020 On a legal phase change, a completed dwell below the phase MIN SHALL set code 3.
REQ-021 When the dwell counter reaches the phase MAX+1, code 4 SHALL be set immediately, without waiting for the phase change.
REQ-022 Fault priority within one cycle SHALL be 1 > 2 > 3 > 4; only the first fault is captured, and later faults leave fault_code unchanged.
REQ-023 In FAULT: fault=1, phase_valid=0, and phase holds the last legal phase.
REQ-024 clr_fault SHALL move the FSM to INIT on the next edge with fault=0, fault_code=0 and phase=3; if a fault condition coincides with clr_fault, the clear SHALL win.
REQ-025 cycle_cnt SHALL increment on each legal GREEN->RED transition, saturate at 16'hFFFF, and not be cleared by clr_fault.
REQ-026 In INIT: phase=3, phase_valid=0.

Reset
REQ-027 rst_n low SHALL immediately force state INIT, phase=3, phase_valid=0, fault=0, fault_code=0, cycle_cnt=0, dwell counter 0, registered led 3'b111.
REQ-028 Reset asserted mid-phase or mid-fault SHALL discard all history; monitoring restarts per REQ-016 after release.

Configuration
REQ-029 Macro TRAFIK_MON_DWELL_CHECK_EN defined: the dwell counter and codes 3/4 are implemented as in REQ-019 to REQ-021.
REQ-030 Macro TRAFIK_MON_DWELL_CHECK_EN undefined: no dwell counter is implemented, codes 3 and 4 are never produced, and pattern/transition checks and cycle_cnt are unchanged.

Verification (RED 8..12, AMB 3..5, GRN 6..8, macro defined)
REQ-031 Legal loop RED 10, AMB 4, GRN 7 cycles, repeated 3 times -> fault=0 throughout, phase sequence 0,1,2, cycle_cnt=3.
REQ-032 RED 10 cycles then led=3'b011 -> fault=1, fault_code=2, two edges after the change; phase stays 0.
REQ-033 led=3'b100 for 1 cycle mid-AMBER -> fault_code=1; a following GREEN does not change the code.
REQ-034 AMBER held 6 cycles -> fault_code=4 asserted on dwell count 6 while led is still AMBER; AMBER held 2 cycles -> fault_code=3.
REQ-035 clr_fault pulse in FAULT followed by a legal GREEN -> INIT (phase=3), then phase=2, fault=0, cycle_cnt unchanged.
REQ-036 rst_n pulled low during GREEN dwell 5 -> all outputs at reset values immediately; after release, GREEN 3 cycles then RED -> no code 3.
